// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
// Drives datapath enables and selects, resolves branches and counts retirements.
module multicycle_ctrl #(
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 alu_zero,
    input  logic                 alu_lt,
    input  logic                 alu_ltu,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 ir_we,
    output logic                 aluout_we,
    output logic [1:0]           alu_src_a,
    output logic                 alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 reg_we,
    output logic [1:0]           result_sel,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic [2:0]           state,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BAD
    } cls_t;

    state_t cur, nxt;
    cls_t   cls;
    logic   taken;
    logic   unused_fields;

    // funct7 is consumed by the ALU decoder, not by sequencing
    assign unused_fields = funct7b5;

    always_comb begin
        cls = C_BAD;
        case (opcode)
            7'b0110011: cls = C_R;
            7'b0010011: cls = C_I;
            7'b0000011: cls = C_LOAD;
            7'b0100011: cls = C_STORE;
            7'b1100011: cls = (funct3[2:1] == 2'b01) ? C_BAD : C_BRANCH;
            7'b0110111: cls = C_LUI;
            7'b0010111: cls = C_AUIPC;
            7'b1101111: cls = C_JAL;
            7'b1100111: cls = C_JALR;
            default:    cls = C_BAD;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = alu_zero;
            3'b001:  taken = !alu_zero;
            3'b100:  taken = alu_lt;
            3'b101:  taken = !alu_lt;
            3'b110:  taken = alu_ltu;
            3'b111:  taken = !alu_ltu;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= FETCH;
        else     cur <= nxt;
    end

    always_comb begin
        nxt        = cur;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        aluout_we  = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 1'b0;
        alu_op     = 2'd0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_we     = 1'b0;
        result_sel = 2'd0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        illegal    = 1'b0;
        state      = cur;
        case (cur)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we = 1'b1;
                    nxt   = DECODE;
                end
            end
            DECODE: nxt = (cls == C_BAD) ? TRAP : EXEC;
            EXEC: begin
                aluout_we = 1'b1;
                nxt       = WB;
                case (cls)
                    C_R: alu_op = 2'd2;
                    C_I: begin
                        alu_src_b = 1'b1;
                        alu_op    = 2'd2;
                    end
                    C_LOAD, C_STORE: begin
                        alu_src_b = 1'b1;
                        nxt       = MEM;
                    end
                    C_JALR: alu_src_b = 1'b1;
                    C_LUI: begin
                        alu_src_a = 2'd2;
                        alu_src_b = 1'b1;
                    end
                    C_AUIPC: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 1'b1;
                    end
                    C_JAL: ;
                    C_BRANCH: begin
                        aluout_we = 1'b0;
                        alu_op    = 2'd1;
                        pc_we     = 1'b1;
                        pc_src    = taken ? 2'd1 : 2'd0;
                        nxt       = FETCH;
                    end
                    default: begin
                        aluout_we = 1'b0;
                        nxt       = TRAP;
                    end
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == C_STORE);
                if (dmem_ready) begin
                    if (cls == C_STORE) begin
                        pc_we = 1'b1;
                        nxt   = FETCH;
                    end else begin
                        nxt = WB;
                    end
                end
            end
            WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                nxt    = FETCH;
                case (cls)
                    C_LOAD: result_sel = 2'd1;
                    C_JAL: begin
                        result_sel = 2'd2;
                        pc_src     = 2'd1;
                    end
                    C_JALR: begin
                        result_sel = 2'd2;
                        pc_src     = 2'd2;
                    end
                    default: ;
                endcase
            end
            TRAP: illegal = 1'b1;
            default: nxt = FETCH;
        endcase
        // Reset masks every output, including the fetch request from FETCH
        if (rst) begin
            imem_req   = 1'b0;
            ir_we      = 1'b0;
            aluout_we  = 1'b0;
            alu_src_a  = 2'd0;
            alu_src_b  = 1'b0;
            alu_op     = 2'd0;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            reg_we     = 1'b0;
            result_sel = 2'd0;
            pc_we      = 1'b0;
            pc_src     = 2'd0;
            illegal    = 1'b0;
            state      = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        instret <= '0;
        else if (pc_we) instret <= instret + INSTRET_W'(1);
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl (4-bit instret so wrap is reachable).
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5, alu_zero, alu_lt, alu_ltu, imem_ready, dmem_ready;
    logic       imem_req, ir_we, aluout_we, alu_src_b, dmem_req, dmem_we, reg_we, pc_we, illegal;
    logic [1:0] alu_src_a, alu_op, result_sel, pc_src;
    logic [2:0] state;
    logic [3:0] instret;

    int tests = 0;
    int fails = 0;

    multicycle_ctrl #(.INSTRET_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_we(ir_we), .aluout_we(aluout_we),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we),
        .result_sel(result_sel), .pc_we(pc_we), .pc_src(pc_src),
        .state(state), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       imem, ir, aw;
        logic [1:0] a;
        logic       b;
        logic [1:0] op;
        logic       dq, dw, rw;
        logic [1:0] rs;
        logic       pw;
        logic [1:0] ps;
        logic       il;
    } out_t;

    typedef struct {
        string      name;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [2:0] flg;   // {zero, lt, ltu}
        logic       ir, dr;
        out_t       e;
    } vec_t;

    vec_t vecs[$];

    function automatic out_t o(int st, int imem, int ir, int aw, int a, int b, int op,
                               int dq, int dw, int rw, int rs, int pw, int ps, int il);
        out_t r;
        r.st = 3'(st); r.imem = 1'(imem); r.ir = 1'(ir); r.aw = 1'(aw);
        r.a = 2'(a); r.b = 1'(b); r.op = 2'(op); r.dq = 1'(dq); r.dw = 1'(dw);
        r.rw = 1'(rw); r.rs = 2'(rs); r.pw = 1'(pw); r.ps = 2'(ps); r.il = 1'(il);
        return r;
    endfunction

    task automatic v(string n, logic [6:0] opc, logic [2:0] f3, logic [2:0] flg,
                     logic ir, logic dr, out_t e);
        vec_t x;
        x.name = n; x.opc = opc; x.f3 = f3; x.flg = flg; x.ir = ir; x.dr = dr; x.e = e;
        vecs.push_back(x);
    endtask

    task automatic chk(string n, out_t e);
        out_t act;
        act = {state, imem_req, ir_we, aluout_we, alu_src_a, alu_src_b, alu_op,
               dmem_req, dmem_we, reg_we, result_sel, pc_we, pc_src, illegal};
        tests++;
        if (act !== e) begin
            fails++;
            $display("FAIL %s: got %h want %h", n, act, e);
        end
    endtask

    task automatic chk_ins(string n, logic [3:0] e);
        tests++;
        if (instret !== e) begin
            fails++;
            $display("FAIL %s: instret got %0d want %0d", n, instret, e);
        end
    endtask

    // Called just after a falling edge; drives, checks mid-low-phase, returns on next falling edge
    task automatic step(string n, logic [6:0] opc, logic [2:0] f3, logic [2:0] flg,
                        logic ir, logic dr, out_t e);
        opcode = opc; funct3 = f3; {alu_zero, alu_lt, alu_ltu} = flg;
        imem_ready = ir; dmem_ready = dr;
        #2;
        chk(n, e);
        @(negedge clk);
    endtask

    task automatic beq_untaken();
        step("beq_f", 7'b1100011, 3'b000, 3'b000, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        step("beq_d", 7'b1100011, 3'b000, 3'b000, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        step("beq_e", 7'b1100011, 3'b000, 3'b000, 0, 0, o(2,0,0,0,0,0,1,0,0,0,0,1,0,0));
    endtask

    task automatic addi();
        step("addi_f", 7'b0010011, 3'b000, 3'b000, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        step("addi_d", 7'b0010011, 3'b000, 3'b000, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        step("addi_e", 7'b0010011, 3'b000, 3'b000, 0, 0, o(2,0,0,1,0,1,2,0,0,0,0,0,0,0));
        step("addi_w", 7'b0010011, 3'b000, 3'b000, 0, 0, o(4,0,0,0,0,0,0,0,0,1,0,1,0,0));
    endtask

    localparam logic [6:0] R = 7'b0110011, LD = 7'b0000011, ST = 7'b0100011,
                           BR = 7'b1100011, LUI = 7'b0110111, AUI = 7'b0010111,
                           JAL = 7'b1101111, JALR = 7'b1100111, OPI = 7'b0010011;

    initial begin
        rst = 1'b1; opcode = R; funct3 = 3'b000; funct7b5 = 1'b1;
        alu_zero = 0; alu_lt = 0; alu_ltu = 0; imem_ready = 1; dmem_ready = 1;

        //   name         opc   f3      zlu    ir dr  st im ir aw a b op dq dw rw rs pw ps il
        v("add_f",    R,    3'b000, 3'b000, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        v("add_d",    R,    3'b000, 3'b000, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        v("add_e",    R,    3'b000, 3'b000, 0, 0, o(2,0,0,1,0,0,2,0,0,0,0,0,0,0));
        v("add_w",    R,    3'b000, 3'b000, 0, 0, o(4,0,0,0,0,0,0,0,0,1,0,1,0,0));
        v("lw_f",     LD,   3'b010, 3'b000, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        v("lw_d",     LD,   3'b010, 3'b000, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        v("lw_e",     LD,   3'b010, 3'b000, 0, 0, o(2,0,0,1,0,1,0,0,0,0,0,0,0,0));
        v("lw_m0",    LD,   3'b010, 3'b000, 0, 0, o(3,0,0,0,0,0,0,1,0,0,0,0,0,0));
        v("lw_m1",    LD,   3'b010, 3'b000, 0, 0, o(3,0,0,0,0,0,0,1,0,0,0,0,0,0));
        v("lw_m2",    LD,   3'b010, 3'b000, 0, 0, o(3,0,0,0,0,0,0,1,0,0,0,0,0,0));
        v("lw_m3",    LD,   3'b010, 3'b000, 0, 1, o(3,0,0,0,0,0,0,1,0,0,0,0,0,0));
        v("lw_w",     LD,   3'b010, 3'b000, 0, 0, o(4,0,0,0,0,0,0,0,0,1,1,1,0,0));
        v("beq_f",    BR,   3'b000, 3'b100, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        v("beq_d",    BR,   3'b000, 3'b100, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        v("beq_e",    BR,   3'b000, 3'b100, 0, 0, o(2,0,0,0,0,0,1,0,0,0,0,1,1,0));
        v("bltu_f",   BR,   3'b110, 3'b110, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        v("bltu_d",   BR,   3'b110, 3'b110, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        v("bltu_e",   BR,   3'b110, 3'b110, 0, 0, o(2,0,0,0,0,0,1,0,0,0,0,1,0,0));
        v("bne_f",    BR,   3'b001, 3'b000, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        v("bne_d",    BR,   3'b001, 3'b000, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        v("bne_e",    BR,   3'b001, 3'b000, 0, 0, o(2,0,0,0,0,0,1,0,0,0,0,1,1,0));
        v("bge_f",    BR,   3'b101, 3'b011, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        v("bge_d",    BR,   3'b101, 3'b011, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        v("bge_e",    BR,   3'b101, 3'b011, 0, 0, o(2,0,0,0,0,0,1,0,0,0,0,1,0,0));
        v("jalr_f",   JALR, 3'b000, 3'b000, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        v("jalr_d",   JALR, 3'b000, 3'b000, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        v("jalr_e",   JALR, 3'b000, 3'b000, 0, 0, o(2,0,0,1,0,1,0,0,0,0,0,0,0,0));
        v("jalr_w",   JALR, 3'b000, 3'b000, 0, 0, o(4,0,0,0,0,0,0,0,0,1,2,1,2,0));
        v("jal_f",    JAL,  3'b000, 3'b000, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        v("jal_d",    JAL,  3'b000, 3'b000, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        v("jal_e",    JAL,  3'b000, 3'b000, 0, 0, o(2,0,0,1,0,0,0,0,0,0,0,0,0,0));
        v("jal_w",    JAL,  3'b000, 3'b000, 0, 0, o(4,0,0,0,0,0,0,0,0,1,2,1,1,0));
        v("sw_f",     ST,   3'b010, 3'b000, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        v("sw_d",     ST,   3'b010, 3'b000, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        v("sw_e",     ST,   3'b010, 3'b000, 0, 0, o(2,0,0,1,0,1,0,0,0,0,0,0,0,0));
        v("sw_m0",    ST,   3'b010, 3'b000, 0, 0, o(3,0,0,0,0,0,0,1,1,0,0,0,0,0));
        v("sw_m1",    ST,   3'b010, 3'b000, 0, 1, o(3,0,0,0,0,0,0,1,1,0,0,1,0,0));
        v("lui_f",    LUI,  3'b000, 3'b000, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        v("lui_d",    LUI,  3'b000, 3'b000, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        v("lui_e",    LUI,  3'b000, 3'b000, 0, 0, o(2,0,0,1,2,1,0,0,0,0,0,0,0,0));
        v("lui_w",    LUI,  3'b000, 3'b000, 0, 0, o(4,0,0,0,0,0,0,0,0,1,0,1,0,0));
        v("auipc_f0", AUI,  3'b000, 3'b000, 0, 1, o(0,1,0,0,0,0,0,0,0,0,0,0,0,0));
        v("auipc_f1", AUI,  3'b000, 3'b000, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        v("auipc_d",  AUI,  3'b000, 3'b000, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        v("auipc_e",  AUI,  3'b000, 3'b000, 0, 0, o(2,0,0,1,1,1,0,0,0,0,0,0,0,0));
        v("auipc_w",  AUI,  3'b000, 3'b000, 0, 0, o(4,0,0,0,0,0,0,0,0,1,0,1,0,0));
        v("addi_f",   OPI,  3'b000, 3'b000, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        v("addi_d",   OPI,  3'b000, 3'b000, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        v("addi_e",   OPI,  3'b000, 3'b000, 0, 0, o(2,0,0,1,0,1,2,0,0,0,0,0,0,0));
        v("addi_w",   OPI,  3'b000, 3'b000, 0, 0, o(4,0,0,0,0,0,0,0,0,1,0,1,0,0));

        // Reset: everything forced low, including imem_req
        #2;
        chk("reset_outs", o(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        chk_ins("reset_instret", 4'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            step(vecs[i].name, vecs[i].opc, vecs[i].f3, vecs[i].flg,
                 vecs[i].ir, vecs[i].dr, vecs[i].e);
        chk_ins("instret_after_table", 4'd12);

        // Wrap: 12 -> 15, then one more retirement rolls to 0
        for (int k = 0; k < 3; k++) beq_untaken();
        chk_ins("instret_all_ones", 4'd15);
        addi();
        chk_ins("instret_wrap", 4'd0);
        addi();
        chk_ins("instret_one", 4'd1);

        // Unsupported opcode traps and stays there
        step("bad_f", 7'b1111111, 3'b000, 3'b000, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        step("bad_d", 7'b1111111, 3'b000, 3'b000, 1, 1, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        for (int k = 0; k < 20; k++)
            step("bad_trap", 7'b1111111, 3'b000, 3'b111, 1, 1, o(5,0,0,0,0,0,0,0,0,0,0,0,0,1));
        chk_ins("trap_instret", 4'd1);

        rst = 1'b1;
        #2;
        chk("trap_reset", o(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rst = 1'b0;

        // BRANCH with reserved funct3 traps as well
        step("br010_f", BR, 3'b010, 3'b000, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        step("br010_d", BR, 3'b010, 3'b000, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        for (int k = 0; k < 3; k++)
            step("br010_trap", BR, 3'b010, 3'b100, 1, 1, o(5,0,0,0,0,0,0,0,0,0,0,0,0,1));
        chk_ins("br010_instret", 4'd0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Async reset in the middle of a store's MEM phase
        addi();
        step("rsw_f", ST, 3'b010, 3'b000, 1, 0, o(0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        step("rsw_d", ST, 3'b010, 3'b000, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        step("rsw_e", ST, 3'b010, 3'b000, 0, 0, o(2,0,0,1,0,1,0,0,0,0,0,0,0,0));
        dmem_ready = 1'b0;
        #2;
        chk("rsw_m", o(3,0,0,0,0,0,0,1,1,0,0,0,0,0));
        chk_ins("rsw_pre_instret", 4'd1);
        dmem_ready = 1'b1;
        imem_ready = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("rsw_async_outs", o(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        chk_ins("rsw_async_instret", 4'd0);
        @(negedge clk);
        rst = 1'b0;
        step("rsw_release", ST, 3'b010, 3'b000, 0, 0, o(0,1,0,0,0,0,0,0,0,0,0,0,0,0));
        chk_ins("rsw_post_instret", 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
